special_result_encoder: RTL and testbench

- Encodes the product for multiplications that hit a special case in the FP HUB multiplier, working from the 3-bit operand codes produced by the special-case detector.
- Sits in parallel with the mantissa/exponent datapath. The final result mux takes Z when z_special is high.
- Registered, with a valid/ready handshake and a 2-entry skid buffer so it can stall with the multiplier pipeline.

---
 rtl/hub_special_pkg.sv | 35 +++
 rtl/special_result_map.sv | 62 ++++++
 rtl/special_result_encoder.sv | 110 +++++++++++
 tb/tb_special_result_encoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/hub_special_pkg.sv
// hub_special_pkg: shared constants and helpers for the FP HUB special-case path.
//   - special_code_t / CASE_*: 3-bit operand codes from the special-case detector.
//   - inf_pat / zero_pat / one_pat: result patterns for the default HUB format
//     (HUB_E exponent bits, HUB_M mantissa bits), for callers at that format.
package hub_special_pkg;

  localparam int HUB_E            = 8;
  localparam int HUB_M            = 23;
  localparam int HUB_SPECIAL_CASE = 7;
  localparam int HUB_CW           = $clog2(HUB_SPECIAL_CASE);

  typedef logic [2:0] special_code_t;

  localparam special_code_t CASE_NONE   = 3'd0;
  localparam special_code_t CASE_INF_P  = 3'd1;
  localparam special_code_t CASE_INF_N  = 3'd2;
  localparam special_code_t CASE_ZERO_P = 3'd3;
  localparam special_code_t CASE_ZERO_N = 3'd4;
  localparam special_code_t CASE_ONE_P  = 3'd5;
  localparam special_code_t CASE_ONE_N  = 3'd6;

  function automatic logic [HUB_E+HUB_M:0] inf_pat(input logic s);
    return {s, {(HUB_E+HUB_M){1'b1}}};
  endfunction

  function automatic logic [HUB_E+HUB_M:0] zero_pat(input logic s);
    return {s, {(HUB_E+HUB_M){1'b0}}};
  endfunction

  // +/-1 in HUB format: only the exponent MSB is set.
  function automatic logic [HUB_E+HUB_M:0] one_pat(input logic s);
    return {s, 1'b1, {(HUB_E+HUB_M-1){1'b0}}};
  endfunction

endpackage

// File: rtl/special_result_map.sv
// special_result_map: combinational mapping of operand special codes to the
// product of a special-case multiplication.
//   x, y        : operands {sign, exponent, mantissa}
//   cx, cy      : operand special codes (values 7+ behave as "none")
//   z           : encoded special result
//   z_special   : z overrides the normal datapath
//   z_invalid   : the product was inf x 0
module special_result_map
  import hub_special_pkg::*;
#(
  parameter int M = 23,
  parameter int E = 8
) (
  input  logic [E+M:0]   x,
  input  logic [E+M:0]   y,
  input  special_code_t  cx,
  input  special_code_t  cy,
  output logic [E+M:0]   z,
  output logic           z_special,
  output logic           z_invalid
);

  logic s;
  logic x_inf, x_zero, x_one, x_none;
  logic y_inf, y_zero, y_one, y_none;

  always_comb begin
    s      = x[E+M] ^ y[E+M];
    x_inf  = (cx == CASE_INF_P)  || (cx == CASE_INF_N);
    x_zero = (cx == CASE_ZERO_P) || (cx == CASE_ZERO_N);
    x_one  = (cx == CASE_ONE_P)  || (cx == CASE_ONE_N);
    y_inf  = (cy == CASE_INF_P)  || (cy == CASE_INF_N);
    y_zero = (cy == CASE_ZERO_P) || (cy == CASE_ZERO_N);
    y_one  = (cy == CASE_ONE_P)  || (cy == CASE_ONE_N);
    // Illegal codes fall through every class and so act as "none".
    x_none = !(x_inf || x_zero || x_one);
    y_none = !(y_inf || y_zero || y_one);

    z         = '0;
    z_special = 1'b1;
    z_invalid = 1'b0;
    if ((x_inf && y_zero) || (y_inf && x_zero)) begin
      // inf x 0 always yields +inf regardless of operand signs.
      z         = {1'b0, {(E+M){1'b1}}};
      z_invalid = 1'b1;
    end else if (x_inf || y_inf) begin
      z = {s, {(E+M){1'b1}}};
    end else if (x_zero || y_zero) begin
      z = {s, {(E+M){1'b0}}};
    end else if (x_one && y_one) begin
      z = {s, 1'b1, {(E+M-1){1'b0}}};
    end else if (x_one && y_none) begin
      // +/-1 times a normal value: pass the other magnitude, fix the sign.
      z = {s, y[E+M-1:0]};
    end else if (y_one && x_none) begin
      z = {s, x[E+M-1:0]};
    end else begin
      z_special = 1'b0;
    end
  end

endmodule

// File: rtl/special_result_encoder.sv
// special_result_encoder: registered special-case product encoder with a
// valid/ready handshake and a 2-entry skid buffer (main + skid register).
//   clk, rst                 : clock, async active-high reset
//   in_valid / in_ready      : upstream handshake (in_ready registered)
//   X, Y                     : operands {sign, exponent, mantissa}
//   X/Y_special_case         : operand special codes
//   out_valid / out_ready    : downstream handshake
//   Z, z_special, z_invalid  : result beat, held while stalled
module special_result_encoder
  import hub_special_pkg::*;
#(
  parameter int M            = 23,
  parameter int E            = 8,
  parameter int SPECIAL_CASE = 7,
  localparam int CW          = $clog2(SPECIAL_CASE),
  localparam int W           = E + M + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  X,
  input  logic [W-1:0]  Y,
  input  logic [CW-1:0] X_special_case,
  input  logic [CW-1:0] Y_special_case,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  Z,
  output logic          z_special,
  output logic          z_invalid
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // Beat layout: {z_invalid, z_special, Z}
  logic [W-1:0] map_z;
  logic         map_special, map_invalid;
  logic [W+1:0] beat;

  logic [1:0]   state_q, state_d;
  logic [W+1:0] main_q, main_d;
  logic [W+1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         accept, pop;

  special_result_map #(.M(M), .E(E)) u_map (
    .x         (X),
    .y         (Y),
    .cx        (X_special_case),
    .cy        (Y_special_case),
    .z         (map_z),
    .z_special (map_special),
    .z_invalid (map_invalid)
  );

  assign beat      = {map_invalid, map_special, map_z};
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign Z         = main_q[W-1:0];
  assign z_special = main_q[W];
  assign z_invalid = main_q[W+1];

  always_comb begin
    accept  = in_valid && in_ready_q;
    pop     = out_valid && out_ready;
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: if (accept) begin
        main_d  = beat;
        state_d = ST_ONE;
      end
      ST_ONE: begin
        if (accept && !pop) begin
          skid_d  = beat;
          state_d = ST_TWO;
        end else if (accept && pop) begin
          main_d  = beat;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: if (pop) begin
        main_d  = skid_q;
        state_d = ST_ONE;
      end
      default: state_d = ST_EMPTY;
    endcase
    // Registered ready: low exactly while the skid register holds a beat.
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_special_result_encoder.sv
module tb_special_result_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] X, Y, Z;
  logic [2:0]  cxs, cys;
  logic        z_special, z_invalid;

  typedef struct {
    logic [31:0] z;
    logic        sp;
    logic        inv;
  } res_t;

  res_t expq[$];
  int   nchecks = 0;
  int   nfail   = 0;
  int   accepts = 0;
  bit   acc_last = 1'b0;

  always #5 clk = ~clk;

  special_result_encoder dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .X              (X),
    .Y              (Y),
    .X_special_case (cxs),
    .Y_special_case (cys),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .Z              (Z),
    .z_special      (z_special),
    .z_invalid      (z_invalid)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: classify each code (0 plain, 1 inf, 2 zero, 3 one), then apply
  // the product rules for IEEE-like special values.
  function automatic res_t ref_model(logic [31:0] x, logic [31:0] y, logic [2:0] cx, logic [2:0] cy);
    int   cls [8];
    int   a, b;
    logic s;
    res_t r;
    cls = '{0, 1, 1, 2, 2, 3, 3, 0};
    a = cls[cx];
    b = cls[cy];
    s = x[31] ^ y[31];
    r.z = 32'h0; r.sp = 1'b1; r.inv = 1'b0;
    if ((a == 1 && b == 2) || (a == 2 && b == 1)) begin
      r.z = 32'h7FFF_FFFF; r.inv = 1'b1;
    end else if (a == 1 || b == 1) r.z = {s, 31'h7FFF_FFFF};
    else if (a == 2 || b == 2)     r.z = {s, 31'h0};
    else if (a == 3 && b == 3)     r.z = {s, 31'h4000_0000};
    else if (a == 3)               r.z = {s, y[30:0]};
    else if (b == 3)               r.z = {s, x[30:0]};
    else                           r.sp = 1'b0;
    return r;
  endfunction

  // Called at a negedge with inputs set; books the handshakes of the coming
  // posedge into the scoreboard, returns at the following negedge.
  task automatic tick();
    res_t e;
    #1;
    acc_last = 1'b0;
    if (out_valid && out_ready) begin
      if (expq.size() == 0) chk("sb_spurious", 1, 0);
      else begin
        e = expq.pop_front();
        chk("sb_z",   Z,         e.z);
        chk("sb_sp",  z_special, e.sp);
        chk("sb_inv", z_invalid, e.inv);
      end
    end
    if (in_valid && in_ready) begin
      expq.push_back(ref_model(X, Y, cxs, cys));
      accepts++;
      acc_last = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic set_beat(logic [2:0] cx, logic [2:0] cy, logic [31:0] x, logic [31:0] y);
    cxs = cx; cys = cy; X = x; Y = y;
  endtask

  task automatic rand_beat();
    set_beat(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom, $urandom);
  endtask

  task automatic directed(string tag, logic [2:0] cx, logic [2:0] cy, logic [31:0] x, logic [31:0] y,
                          logic [31:0] ez, logic es, logic ei);
    set_beat(cx, cy, x, y);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_z"},   Z,         ez);
    chk({tag, "_sp"},  z_special, es);
    chk({tag, "_inv"}, z_invalid, ei);
    tick();
  endtask

  task automatic drain(string tag);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && expq.size() != 0; i++) tick();
    chk(tag, expq.size(), 0);
    chk({tag, "_idle"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", nchecks, nfail);
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_beat(3'd0, 3'd0, 32'h0, 32'h0);
    @(negedge clk); @(negedge clk);
    chk("rst_ovld", out_valid, 0);
    chk("rst_rdy",  in_ready,  1);
    chk("rst_z",    Z,         0);
    chk("rst_sp",   z_special, 0);
    chk("rst_inv",  z_invalid, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    directed("pinf_nzero", 3'd1, 3'd4, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1, 1);
    directed("ninf_pone",  3'd2, 3'd5, 32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF, 1, 0);
    directed("none_norm",  3'd6, 3'd0, 32'hC000_0000, 32'h3F80_0000, 32'hBF80_0000, 1, 0);
    directed("one_one",    3'd5, 3'd6, 32'h3F80_0000, 32'hBF80_0000, 32'hC000_0000, 1, 0);
    directed("plain",      3'd0, 3'd0, 32'h3F80_0000, 32'h4040_0000, 32'h0000_0000, 0, 0);
    directed("ill_zero",   3'd7, 3'd3, 32'h3F80_0000, 32'h0000_0000, 32'h0000_0000, 1, 0);
    directed("ill_one",    3'd7, 3'd5, 32'h4040_0000, 32'hBF80_0000, 32'hC040_0000, 1, 0);
    directed("zero_ninf",  3'd3, 3'd2, 32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1, 1);

    // Stall: A and B accepted, C held upstream, then drained in order.
    base = accepts;
    out_ready = 1'b0; in_valid = 1'b1;
    set_beat(3'd5, 3'd0, 32'h3F80_0000, 32'h4049_0FDB);   // A -> 0x40490FDB
    tick();
    chk("stall_rdy_a", in_ready, 1);
    set_beat(3'd0, 3'd6, 32'h4000_0000, 32'hBF80_0000);   // B -> 0xC0000000
    tick();
    chk("stall_rdy_b", in_ready, 0);
    chk("stall_z_a",   Z, 32'h4049_0FDB);
    set_beat(3'd4, 3'd3, 32'h8000_0000, 32'h0000_0000);   // C -> 0x80000000
    tick(); tick();
    chk("stall_rdy_c", in_ready, 0);
    chk("stall_held",  accepts - base, 2);
    chk("stall_hold_z", Z, 32'h4049_0FDB);
    chk("stall_hold_v", out_valid, 1);
    out_ready = 1'b1;
    tick();
    chk("rel_v_b", out_valid, 1);
    chk("rel_z_b", Z, 32'h C000_0000);
    tick();
    in_valid = 1'b0;
    chk("rel_v_c", out_valid, 1);
    chk("rel_z_c", Z, 32'h8000_0000);
    chk("rel_acc", accepts - base, 3);
    tick();
    chk("rel_done", out_valid, 0);

    // Random traffic with upstream holding a refused beat.
    rand_beat();
    for (int i = 0; i < 1500; i++) begin
      if (!in_valid || acc_last) rand_beat();
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("rand_drain");

    // Continuous stream, async reset mid-stream, clean resume.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_beat();
      tick();
      chk("strm_vld", out_valid, 1);
      chk("strm_rdy", in_ready,  1);
    end
    #2 rst = 1'b1;
    #1;
    chk("mrst_ovld", out_valid, 0);
    chk("mrst_rdy",  in_ready,  1);
    chk("mrst_sp",   z_special, 0);
    chk("mrst_z",    Z,         0);
    expq.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rand_beat();
      tick();
      chk("resume_vld", out_valid, 1);
      chk("resume_rdy", in_ready,  1);
    end
    drain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
